// File: rtl/expand_key_top.sv
// AES-128 key expansion. One round (four words) is produced per clock
// by a single iterative datapath. The schedule recomputes whenever the
// key presented at in_key differs from the key that was last captured.
module expand_key_top (
  input  logic           clk,
  input  logic           rst,
  input  logic [127:0]   in_key,
  output logic [1407:0]  full_expanded_key,
  output logic           ready
);

  typedef enum logic [1:0] {LOAD, EXPAND, DONE} state_e;

  // Standard AES S-box, entry 0 at the most significant end.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_e          state_q, state_d;
  logic [127:0]    key_q, key_d;
  logic [127:0]    prev_q, prev_d;   // last four words written
  logic [1407:0]   fek_q, fek_d;
  logic [3:0]      cnt_q, cnt_d;

  logic [31:0]     rot_w, sub_w, rcon_w, n0, n1, n2, n3;
  logic [127:0]    round_w;
  logic            key_changed;

  assign key_changed = (in_key != key_q);

  // Round constant for the round currently being computed.
  always_comb begin
    rcon_w = 32'h0;
    case (cnt_q)
      4'd1:    rcon_w = 32'h01000000;
      4'd2:    rcon_w = 32'h02000000;
      4'd3:    rcon_w = 32'h04000000;
      4'd4:    rcon_w = 32'h08000000;
      4'd5:    rcon_w = 32'h10000000;
      4'd6:    rcon_w = 32'h20000000;
      4'd7:    rcon_w = 32'h40000000;
      4'd8:    rcon_w = 32'h80000000;
      4'd9:    rcon_w = 32'h1b000000;
      4'd10:   rcon_w = 32'h36000000;
      default: rcon_w = 32'h0;
    endcase
  end

  // One full round: RotWord/SubWord on the last word, then the XOR chain.
  always_comb begin
    rot_w   = {prev_q[119:96], prev_q[127:120]};
    sub_w   = {SBOX[rot_w[31:24]], SBOX[rot_w[23:16]],
               SBOX[rot_w[15:8]],  SBOX[rot_w[7:0]]};
    n0      = prev_q[31:0]   ^ sub_w ^ rcon_w;
    n1      = prev_q[63:32]  ^ n0;
    n2      = prev_q[95:64]  ^ n1;
    n3      = prev_q[127:96] ^ n2;
    round_w = {n3, n2, n1, n0};
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= LOAD;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    state_d = EXPAND;
      EXPAND:  if (cnt_q == 4'd10) state_d = DONE;
      DONE:    if (key_changed) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Outputs: the schedule is only complete while sitting in DONE.
  always_comb begin
    ready             = (state_q == DONE);
    full_expanded_key = fek_q;
  end

  // Datapath next-state: capture key, fill one round slot per cycle.
  always_comb begin
    key_d  = key_q;
    prev_d = prev_q;
    fek_d  = fek_q;
    cnt_d  = cnt_q;
    case (state_q)
      LOAD: begin
        key_d  = in_key;
        prev_d = in_key;
        fek_d  = {1280'b0, in_key};
        cnt_d  = 4'd1;
      end
      EXPAND: begin
        fek_d[{cnt_q, 7'd0} +: 128] = round_w;
        prev_d = round_w;
        if (cnt_q != 4'd10) cnt_d = cnt_q + 4'd1;
      end
      DONE: begin
        // Leaving DONE wipes the stale schedule so uncomputed words read zero.
        if (key_changed) begin
          fek_d = '0;
          cnt_d = 4'd0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q  <= '0;
      prev_q <= '0;
      fek_q  <= '0;
      cnt_q  <= '0;
    end else begin
      key_q  <= key_d;
      prev_q <= prev_d;
      fek_q  <= fek_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_expand_key_top.sv
// Bench for expand_key_top: known-answer vectors, randomized key changes
// against a key-schedule model whose S-box is derived from GF(2^8).
module tb_expand_key_top;

  logic          clk;
  logic          rst;
  logic [127:0]  in_key;
  logic [1407:0] full_expanded_key;
  logic          ready;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb [256];
  logic [7:0] rc [11];

  typedef struct {
    logic [127:0] key;
    logic [31:0]  w4;
    logic [127:0] last;
  } vec_t;
  vec_t vecs [2];

  expand_key_top dut (
    .clk               (clk),
    .rst               (rst),
    .in_key            (in_key),
    .full_expanded_key (full_expanded_key),
    .ready             (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box = affine transform of the multiplicative inverse; Rcon by doubling.
  task automatic build_tables();
    logic [7:0] inv, r;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    r = 8'h01;
    rc[0] = 8'h00;
    for (int j = 1; j <= 10; j++) begin
      rc[j] = r;
      r = xt(r);
    end
  endtask

  function automatic logic [1407:0] model(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [1407:0] s;
    for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) s[32*i +: 32] = w[i];
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_sched(input string name, input logic [1407:0] act, input logic [1407:0] exp);
    int bad;
    checks++;
    if (act !== exp) begin
      failures++;
      bad = 0;
      for (int i = 43; i >= 0; i--)
        if (act[32*i +: 32] !== exp[32*i +: 32]) bad = i;
      $display("FAIL %s word %0d got %h expected %h", name, bad,
               act[32*bad +: 32], exp[32*bad +: 32]);
    end
  endtask

  // Hold reset for two edges, release mid-cycle; next posedge is edge 1.
  task automatic do_reset(input logic [127:0] k);
    in_key = k;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Count edges until ready, bounded; n is advanced from its start value.
  task automatic wait_ready(inout int n);
    while (!ready && n < 40) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [127:0] rkey();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int n;
    logic [127:0] ka, kb;
    logic [1407:0] exp_s;

    build_tables();
    vecs[0] = '{128'h0c0d0e0f08090a0b0405060700010203, 32'hd6aa74fd,
                128'h4d2b30c5f307a78be3944a1713111d7f};
    vecs[1] = '{128'h09cf4f3cabf7158828aed2a62b7e1516, 32'ha0fafe17,
                128'hb6630ca6e13f0cc8c9ee2589d014f9a8};

    // Asynchronous reset: outputs clear with no clock edge.
    rst = 1'b1;
    in_key = rkey();
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    chk("async_rst_ready", {127'b0, ready}, 128'h0);
    chk_sched("async_rst_sched", full_expanded_key, '0);
    tick();
    chk("held_rst_ready", {127'b0, ready}, 128'h0);
    rst = 1'b1;

    // Known-answer table.
    for (int v = 0; v < 2; v++) begin
      do_reset(vecs[v].key);
      tick();
      chk("load_ready", {127'b0, ready}, 128'h0);
      chk_sched("load_sched", full_expanded_key, {1280'b0, vecs[v].key});
      n = 1;
      wait_ready(n);
      chk("kat_latency", 128'(n), 128'd11);
      chk("kat_w4", {96'b0, full_expanded_key[159:128]}, {96'b0, vecs[v].w4});
      chk("kat_w40_43", full_expanded_key[1407:1280], vecs[v].last);
      chk_sched("kat_model", full_expanded_key, model(vecs[v].key));
      tick(); tick(); tick();
      chk("hold_ready", {127'b0, ready}, 128'h1);
      chk_sched("hold_sched", full_expanded_key, model(vecs[v].key));
    end

    // Random key changes while in DONE.
    for (int r = 0; r < 4; r++) begin
      ka = rkey();
      in_key = ka;
      tick();
      chk("chg_drop_ready", {127'b0, ready}, 128'h0);
      chk_sched("chg_drop_sched", full_expanded_key, '0);
      n = 0;
      wait_ready(n);
      chk("chg_latency", 128'(n), 128'd11);
      chk_sched("chg_model", full_expanded_key, model(ka));
    end

    // Key change during expansion is ignored until the schedule completes.
    ka = rkey();
    kb = rkey();
    do_reset(ka);
    for (int e = 0; e < 5; e++) tick();
    in_key = kb;
    n = 5;
    wait_ready(n);
    chk("mid_chg_latency", 128'(n), 128'd11);
    chk_sched("mid_chg_old", full_expanded_key, model(ka));
    tick();
    chk("mid_chg_drop", {127'b0, ready}, 128'h0);
    n = 0;
    wait_ready(n);
    chk("mid_chg_relatency", 128'(n), 128'd11);
    chk_sched("mid_chg_new", full_expanded_key, model(kb));

    // Reset pulse mid-expansion aborts and restarts.
    ka = rkey();
    do_reset(ka);
    for (int e = 0; e < 6; e++) tick();
    rst = 1'b0;
    #1;
    chk("abort_ready", {127'b0, ready}, 128'h0);
    chk_sched("abort_sched", full_expanded_key, '0);
    tick();
    rst = 1'b1;
    n = 0;
    wait_ready(n);
    chk("abort_latency", 128'(n), 128'd11);
    exp_s = model(ka);
    chk_sched("abort_model", full_expanded_key, exp_s);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
